// File: rtl/alu_resp.sv
// Purpose : responder-side ALU core, input capture stage then registered compute stage.
// Latency : 2 clk edges from ALU_en sampling to c_valid; one op per cycle sustained.
// Backpr. : none; every sampled ALU_en completes, the consumer must accept c each cycle.
//
// Ports:
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   ALU_en               operation request, sampled every posedge
//   a_en, b_en           opcode table select (A-group / B-group; both set is illegal)
//   a_op, b_op           A-group (3b) and B-group (2b) opcodes
//   A, B                 signed DATA_W operands
//   c                    signed DATA_W+1 registered result, holds between completions
//   c_valid, err         one-cycle strobes for a completing op / an illegal completing op
//   op_cnt               saturating count of completed ops (legal, illegal and no-op)
//   err_sticky           only with ALU_RESP_ERR_STICKY_EN defined: set by any err, cleared by rst
module alu_resp #(
   parameter int DATA_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ALU_en,
   input  logic                     a_en,
   input  logic                     b_en,
   input  logic [2:0]               a_op,
   input  logic [1:0]               b_op,
   input  logic signed [DATA_W-1:0] A,
   input  logic signed [DATA_W-1:0] B,
   output logic signed [DATA_W:0]   c,
   output logic                     c_valid,
   output logic                     err,
`ifdef ALU_RESP_ERR_STICKY_EN
   output logic                     err_sticky,
`endif
   output logic [CNT_W-1:0]         op_cnt
);

   // Stage 1: captured request
   logic                     s1_valid;
   logic                     s1_a_en;
   logic                     s1_b_en;
   logic [2:0]               s1_a_op;
   logic [1:0]               s1_b_op;
   logic signed [DATA_W-1:0] s1_a;
   logic signed [DATA_W-1:0] s1_b;

   // Stage 2 combinational compute
   logic signed [DATA_W:0]   s1_ax;
   logic signed [DATA_W:0]   s1_bx;
   logic [DATA_W-1:0]        lg;
   logic                     use_lg;
   logic                     ill;
   logic signed [DATA_W:0]   res_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a_en  <= 1'b0;
         s1_b_en  <= 1'b0;
         s1_a_op  <= '0;
         s1_b_op  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= ALU_en;
         // Controls are only meaningful with ALU_en, so capture only then.
         if (ALU_en) begin
            s1_a_en <= a_en;
            s1_b_en <= b_en;
            s1_a_op <= a_op;
            s1_b_op <= b_op;
            s1_a    <= A;
            s1_b    <= B;
         end
      end
   end

   always_comb begin
      // Sign-extend so the full -32..31 sum/difference range is representable.
      s1_ax   = {s1_a[DATA_W-1], s1_a};
      s1_bx   = {s1_b[DATA_W-1], s1_b};
      res_nxt = c;          // no-op (neither table selected) keeps c
      lg      = '0;
      use_lg  = 1'b0;
      ill     = 1'b0;
      case ({s1_a_en, s1_b_en})
         2'b10: begin
            case (s1_a_op)
               3'd0:    res_nxt = s1_ax + s1_bx;
               3'd1:    res_nxt = s1_ax - s1_bx;
               3'd2:    begin lg = s1_a ^ s1_b;    use_lg = 1'b1; end
               3'd3:    begin lg = s1_a & s1_b;    use_lg = 1'b1; end
               3'd4:    begin lg = s1_a | s1_b;    use_lg = 1'b1; end
               3'd5:    begin lg = ~(s1_a ^ s1_b); use_lg = 1'b1; end
               default: ill = 1'b1;
            endcase
         end
         2'b01: begin
            case (s1_b_op)
               2'd0:    begin lg = ~(s1_a & s1_b); use_lg = 1'b1; end
               2'd1:    res_nxt = s1_ax + s1_bx;
               2'd2:    res_nxt = s1_bx - s1_ax;
               default: ill = 1'b1;
            endcase
         end
         2'b11:   ill = 1'b1;
         default: ;
      endcase
      // Logic results are DATA_W wide and sign-extended into c.
      if (use_lg) res_nxt = {lg[DATA_W-1], lg};
      if (ill)    res_nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c       <= '0;
         c_valid <= 1'b0;
         err     <= 1'b0;
         op_cnt  <= '0;
      end else begin
         c_valid <= s1_valid;
         err     <= s1_valid & ill;
         if (s1_valid) begin
            c <= res_nxt;
            if (op_cnt != {CNT_W{1'b1}}) op_cnt <= op_cnt + 1'b1;
         end
      end
   end

`ifdef ALU_RESP_ERR_STICKY_EN
   // Set on the same edge that raises err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  err_sticky <= 1'b0;
      else if (s1_valid && ill) err_sticky <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_alu_resp.sv
// Purpose : directed self-checking bench for alu_resp.
// Latency : results checked 2 edges after the request edge.
// Backpr. : none; inputs driven 1 time unit after each posedge, outputs sampled there too.
module tb_alu_resp;

   logic              clk;
   logic              rst;
   logic              ALU_en;
   logic              a_en;
   logic              b_en;
   logic [2:0]        a_op;
   logic [1:0]        b_op;
   logic signed [4:0] A;
   logic signed [4:0] B;
   logic signed [5:0] c;
   logic              c_valid;
   logic              err;
   logic [7:0]        op_cnt;
`ifdef ALU_RESP_ERR_STICKY_EN
   logic              err_sticky;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   alu_resp #(.DATA_W(5), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALU_en     (ALU_en),
      .a_en       (a_en),
      .b_en       (b_en),
      .a_op       (a_op),
      .b_op       (b_op),
      .A          (A),
      .B          (B),
      .c          (c),
      .c_valid    (c_valid),
      .err        (err),
`ifdef ALU_RESP_ERR_STICKY_EN
      .err_sticky (err_sticky),
`endif
      .op_cnt     (op_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Issue one op, wait for its completion edge, check every output.
   task automatic run_op(input string tag, input logic ae, input logic be,
                         input logic [2:0] aop, input logic [1:0] bop,
                         input logic signed [4:0] va, input logic signed [4:0] vb,
                         input int exp_c, input logic exp_err);
      ALU_en = 1'b1; a_en = ae; b_en = be; a_op = aop; b_op = bop; A = va; B = vb;
      tick();
      ALU_en = 1'b0;
      tick();
      if (exp_cnt < 255) exp_cnt++;
      chk({tag, ".c"}, c, exp_c);
      chk({tag, ".c_valid"}, c_valid, 1);
      chk({tag, ".err"}, err, exp_err);
      chk({tag, ".op_cnt"}, op_cnt, exp_cnt);
   endtask

   initial begin
      rst = 1'b1; ALU_en = 1'b0; a_en = 1'b0; b_en = 1'b0;
      a_op = '0; b_op = '0; A = '0; B = '0;
      tick(); tick();
      chk("rst.c", c, 0);
      chk("rst.c_valid", c_valid, 0);
      chk("rst.err", err, 0);
      chk("rst.op_cnt", op_cnt, 0);
      rst = 1'b0;
      tick(); tick();
      chk("idle.c_valid", c_valid, 0);
      chk("idle.op_cnt", op_cnt, 0);

      // 7 + -3 = 4, strobe lasts one cycle and c holds
      run_op("add", 1, 0, 3'd0, 2'd0, 5'sd7, -5'sd3, 4, 0);
`ifdef ALU_RESP_ERR_STICKY_EN
      chk("sticky.clear", err_sticky, 0);
`endif
      tick();
      chk("add.valid_drop", c_valid, 0);
      chk("add.c_hold", c, 4);

      // Back-to-back: -16 + -16 = -32, then 15 - -16 = 31
      ALU_en = 1'b1; a_en = 1'b1; b_en = 1'b0; a_op = 3'd0; A = -5'sd16; B = -5'sd16;
      tick();
      a_op = 3'd1; A = 5'sd15; B = -5'sd16;
      tick();
      ALU_en = 1'b0;
      chk("b2b.c0", c, -32);
      chk("b2b.valid0", c_valid, 1);
      tick();
      chk("b2b.c1", c, 31);
      chk("b2b.valid1", c_valid, 1);
      exp_cnt += 2;
      chk("b2b.op_cnt", op_cnt, exp_cnt);
      tick();
      chk("b2b.valid_drop", c_valid, 0);

      // A-group logic ops: 01100 ^ 00110 = 01010; ~ = 10101
      run_op("xor",  1, 0, 3'd2, 2'd0, 5'sd12, 5'sd6, 10, 0);
      run_op("and",  1, 0, 3'd3, 2'd0, -5'sd1, -5'sd16, -16, 0);
      run_op("or",   1, 0, 3'd4, 2'd0, 5'sd8, 5'sd3, 11, 0);
      run_op("xnor", 1, 0, 3'd5, 2'd0, 5'sd12, 5'sd6, -11, 0);
      // B-group: ~(01010 & 00110) = 11101 = -3; -5 + 2 = -3; B-A = -4-3 = -7
      run_op("nand", 0, 1, 3'd0, 2'd0, 5'sd10, 5'sd6, -3, 0);
      run_op("badd", 0, 1, 3'd0, 2'd1, -5'sd5, 5'sd2, -3, 0);
      run_op("bsub", 0, 1, 3'd0, 2'd2, 5'sd3, -5'sd4, -7, 0);
      // No-op completes but keeps c
      run_op("noop", 0, 0, 3'd0, 2'd0, 5'sd9, 5'sd9, -7, 0);

      // Illegal ops force c=0 with err
      run_op("ill_a6", 1, 0, 3'd6, 2'd0, 5'sd3, 5'sd3, 0, 1);
`ifdef ALU_RESP_ERR_STICKY_EN
      chk("sticky.set", err_sticky, 1);
`endif
      run_op("ok_mid", 1, 0, 3'd0, 2'd0, 5'sd1, 5'sd2, 3, 0);
`ifdef ALU_RESP_ERR_STICKY_EN
      chk("sticky.hold", err_sticky, 1);
`endif
      run_op("ill_ab", 1, 1, 3'd0, 2'd0, 5'sd3, 5'sd3, 0, 1);
      run_op("ill_b3", 0, 1, 3'd0, 2'd3, 5'sd3, 5'sd3, 0, 1);
      tick();
      chk("ill.err_drop", err, 0);

      // Reset while an op sits in stage 1: it must never complete
      ALU_en = 1'b1; a_en = 1'b1; b_en = 1'b0; a_op = 3'd0; A = 5'sd1; B = 5'sd1;
      tick();
      ALU_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst.c", c, 0);
      chk("midrst.op_cnt", op_cnt, 0);
`ifdef ALU_RESP_ERR_STICKY_EN
      chk("midrst.sticky", err_sticky, 0);
`endif
      tick();
      chk("midrst.valid0", c_valid, 0);
      tick();
      chk("midrst.valid1", c_valid, 0);
      chk("midrst.op_cnt2", op_cnt, 0);

      // 260 back-to-back ops saturate the counter at 255
      ALU_en = 1'b1; a_en = 1'b1; b_en = 1'b0; a_op = 3'd0; A = 5'sd1; B = 5'sd1;
      repeat (260) tick();
      ALU_en = 1'b0;
      chk("sat.stream_valid", c_valid, 1);
      tick();
      tick();
      chk("sat.op_cnt", op_cnt, 255);
      chk("sat.c", c, 2);
      chk("sat.valid_drop", c_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
